// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array and its upstream feeder.
package systolic_pkg;

    localparam int DEF_MAC_NUM  = 10;
    localparam int DEF_ACCU_NUM = 5;
    localparam int DEF_BW_ACT   = 8;
    localparam int DEF_BW_WET   = 8;
    localparam int DEF_CNT_W    = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_ACT = 3'd1,
        CLEAR    = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/systolic_feeder.sv
// Loads one activation vector, then drives clear / weight stream / drain / done
// into the 1xN systolic MAC array.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int MAC_NUM  = DEF_MAC_NUM,
    parameter int ACCU_NUM = DEF_ACCU_NUM,
    parameter int BW_ACT   = DEF_BW_ACT,
    parameter int BW_WET   = DEF_BW_WET,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     act_valid,
    output logic                     act_ready,
    input  logic signed [BW_ACT-1:0] act_data,
    input  logic                     wet_valid,
    output logic                     wet_ready,
    input  logic signed [BW_WET-1:0] wet_data,
    output logic                     PE_mac_enable,
    output logic                     PE_clear_acc,
    output logic signed [BW_ACT-1:0] PE_act_out [ACCU_NUM],
    output logic signed [BW_WET-1:0] PE_wet_out,
    output logic                     busy,
    output logic                     done
);

    localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(ACCU_NUM - 1);
    localparam logic [CNT_W-1:0] WET_LAST = CNT_W'(MAC_NUM - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         act_cnt_q, act_cnt_d;
    logic [CNT_W-1:0]         wet_cnt_q, wet_cnt_d;
    logic [CNT_W-1:0]         drain_cnt_q, drain_cnt_d;
    logic signed [BW_ACT-1:0] act_vec_q [ACCU_NUM];
    logic signed [BW_ACT-1:0] act_vec_d [ACCU_NUM];
    logic signed [BW_WET-1:0] wet_q, wet_d;
    logic                     mac_en_q, mac_en_d;
    logic                     clear_q, clear_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     act_fire, wet_fire;

    assign act_ready = (state_q == LOAD_ACT);
    assign wet_ready = (state_q == STREAM);
    assign act_fire  = act_valid && act_ready;
    assign wet_fire  = wet_valid && wet_ready;

    always_comb begin
        state_d     = state_q;
        act_cnt_d   = act_cnt_q;
        wet_cnt_d   = wet_cnt_q;
        drain_cnt_d = drain_cnt_q;
        act_vec_d   = act_vec_q;
        wet_d       = '0;
        mac_en_d    = 1'b0;
        clear_d     = 1'b0;
        done_d      = 1'b0;

        // Array-facing outputs are registered off the current state, so each
        // one shows up the cycle after the state that produced it.
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_ACT;
            end
            LOAD_ACT: begin
                if (act_fire) begin
                    for (int i = 0; i < ACCU_NUM; i++) begin
                        if (act_cnt_q == CNT_W'(i)) act_vec_d[i] = act_data;
                    end
                    if (act_cnt_q == ACT_LAST) begin
                        act_cnt_d = '0;
                        state_d   = CLEAR;
                    end else begin
                        act_cnt_d = act_cnt_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                clear_d = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (wet_fire) begin
                    wet_d    = wet_data;
                    mac_en_d = 1'b1;
                    if (wet_cnt_q == WET_LAST) begin
                        wet_cnt_d = '0;
                        state_d   = DRAIN;
                    end else begin
                        wet_cnt_d = wet_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Zero weights with enable push the last partial sums out of the chain.
                mac_en_d = 1'b1;
                if (drain_cnt_q == ACT_LAST) begin
                    drain_cnt_d = '0;
                    state_d     = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            act_cnt_q   <= '0;
            wet_cnt_q   <= '0;
            drain_cnt_q <= '0;
            for (int i = 0; i < ACCU_NUM; i++) act_vec_q[i] <= '0;
            wet_q       <= '0;
            mac_en_q    <= 1'b0;
            clear_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_cnt_q   <= act_cnt_d;
            wet_cnt_q   <= wet_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            act_vec_q   <= act_vec_d;
            wet_q       <= wet_d;
            mac_en_q    <= mac_en_d;
            clear_q     <= clear_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign PE_act_out    = act_vec_q;
    assign PE_wet_out    = wet_q;
    assign PE_mac_enable = mac_en_q;
    assign PE_clear_acc  = clear_q;
    assign done          = done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboarded bench for systolic_feeder: weights queued as driven, popped on MAC enable.
module tb_systolic_feeder;

    logic              clk;
    logic              reset;
    logic              start;
    logic              act_valid, act_ready;
    logic signed [7:0] act_data;
    logic              wet_valid, wet_ready;
    logic signed [7:0] wet_data;
    logic              PE_mac_enable, PE_clear_acc;
    logic signed [7:0] PE_act_out [5];
    logic signed [7:0] PE_wet_out;
    logic              busy, done;

    systolic_feeder dut (
        .clk(clk), .reset(reset), .start(start),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .wet_valid(wet_valid), .wet_ready(wet_ready), .wet_data(wet_data),
        .PE_mac_enable(PE_mac_enable), .PE_clear_acc(PE_clear_acc),
        .PE_act_out(PE_act_out), .PE_wet_out(PE_wet_out),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    logic signed [7:0] sb [$];
    int busy_cnt = 0, clr_cnt = 0, done_cnt = 0, en_cnt = 0;
    logic prev_ar = 1'b0, prev_wr = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (busy) busy_cnt++;
            if (PE_mac_enable) en_cnt++;
            if (PE_clear_acc) begin
                clr_cnt++;
                chk("rdy_in_clear", int'({prev_ar, prev_wr}), 0);
            end
            if (done) begin
                done_cnt++;
                chk("rdy_in_done", int'({prev_ar, prev_wr}), 0);
            end
            if (!busy) chk("rdy_in_idle", int'({act_ready, wet_ready}), 0);
            if (PE_mac_enable) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else chk("wet_out", int'(PE_wet_out), int'(sb.pop_front()));
            end else begin
                chk("wet_off_zero", int'(PE_wet_out), 0);
            end
        end
        prev_ar = act_ready;
        prev_wr = wet_ready;
    end

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_en"}, int'(PE_mac_enable), 0);
        chk({tag, "_clr"}, int'(PE_clear_acc), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_wet"}, int'(PE_wet_out), 0);
        for (int i = 0; i < 5; i++) chk({tag, "_act"}, int'(PE_act_out[i]), 0);
    endtask

    task automatic run_job(input logic signed [7:0] a [5], input logic signed [7:0] w [10],
                           input bit bub, input bit tog, input bit noise,
                           input int exp_busy, input bit abort3);
        int b0, c0, d0, e0, cyc, ai, wi;
        bit pend;
        b0 = busy_cnt; c0 = clr_cnt; d0 = done_cnt; e0 = en_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ai = 0; cyc = 0;
        while (ai < 5 && cyc < 100) begin
            act_valid = tog ? (cyc % 2 == 0) : 1'b1;
            act_data  = a[ai];
            if (act_valid && act_ready) ai++;
            @(negedge clk);
            cyc++;
        end
        act_valid = 1'b0;
        chk("act_load_timeout", ai, 5);
        wi = 0; cyc = 0; pend = 1'b0;
        start = noise;
        while (wi < 10 && cyc < 100) begin
            if (pend) begin
                wet_valid = 1'b0;
                pend = 1'b0;
            end else begin
                wet_valid = 1'b1;
                wet_data  = w[wi];
                if (wet_ready) begin
                    sb.push_back(w[wi]);
                    wi++;
                    if (bub && (wi == 3 || wi == 7)) pend = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
            if (abort3 && wi == 3) break;
        end
        wet_valid = 1'b0;
        if (abort3) begin
            start = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk_idle_zero("abort");
            chk("abort_rdy", int'({act_ready, wet_ready}), 0);
            return;
        end
        chk("wet_stream_timeout", wi, 10);
        for (int k = 0; k < 5; k++) sb.push_back(8'sd0);
        if (noise) begin
            repeat (6) @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("clear_pulses", clr_cnt - c0, 1);
        chk("busy_cycles", busy_cnt - b0, exp_busy);
        chk("enabled_cycles", en_cnt - e0, 15);
        chk("busy_after", int'(busy), 0);
        chk("sb_drained", sb.size(), 0);
        for (int i = 0; i < 5; i++) chk("act_vec", int'(PE_act_out[i]), int'(a[i]));
    endtask

    logic signed [7:0] acts1 [5];
    logic signed [7:0] acts2 [5];
    logic signed [7:0] w1 [10];
    logic signed [7:0] w2 [10];

    initial begin
        acts1 = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5};
        acts2 = '{-8'sd1, -8'sd128, 8'sd127, 8'sd0, 8'sd5};
        w1    = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9, 8'sd10};
        w2    = '{-8'sd5, 8'sd127, -8'sd128, 8'sd0, -8'sd1, 8'sd64, 8'sd3, -8'sd77, 8'sd9, 8'sd1};
        reset = 1'b1; start = 1'b0;
        act_valid = 1'b0; act_data = '0;
        wet_valid = 1'b0; wet_data = '0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        chk("reset_rdy", int'({act_ready, wet_ready}), 0);
        reset = 1'b0;
        @(negedge clk);

        run_job(acts1, w1, 1'b0, 1'b0, 1'b0, 22, 1'b0);
        run_job(acts2, w2, 1'b1, 1'b0, 1'b0, 24, 1'b0);
        run_job(acts2, w1, 1'b0, 1'b1, 1'b0, 26, 1'b0);
        run_job(acts1, w2, 1'b0, 1'b0, 1'b1, 22, 1'b0);
        run_job(acts2, w1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        repeat (2) @(negedge clk);
        run_job(acts1, w1, 1'b0, 1'b0, 1'b0, 22, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
